sort_sched: RTL and testbench
=============================

Name: sort_sched

Overview:
- Round-robin scheduler that shares one pipelined 3-input sorter (pplsort) among NREQ requesters.
- Arbitrates the requests and issues one operand triple per cycle to the sorter.
- Tracks each in-flight sort with a tag pipeline matched to the sorter latency.
- Routes each sorted result back to the requester that issued it. Sits between the requesting engines and the single pplsort instance.

Parameters:
WIDTH, 3, bit width of each operand (a, b, c) and each result (no1, no2, no3).
NREQ, 4, number of requesters (2..8).
LAT, 1, sorter latency in clock edges from operands registered at the sorter input to no1..no3 valid.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  NREQ  per-requester request valid.
req_ready  output  NREQ  per-requester grant; combinational; at most one bit high.
req_data  input  NREQ*3*WIDTH  requester i at slice [i*3*WIDTH +: 3*WIDTH], packed {a,b,c}.
srt_a, srt_b, srt_c  output  WIDTH each  registered operands to the sorter.
srt_no1, srt_no2, srt_no3  input  WIDTH each  sorter outputs, no1 largest.
rsp_valid  output  NREQ  one-hot result strobe, one cycle per result.
rsp_data  output  3*WIDTH  {srt_no1,srt_no2,srt_no3}, passed through combinationally.
rsp_id  output  clog2(NREQ)  index of the owning requester, valid while any rsp_valid bit is high.
busy  output  1  high while any tag stage is valid.
done_cnt  output  16  count of delivered results; wraps 0xFFFF->0.

Behaviour:
- Reset (rst=0, async) clears:
  - srt_a/b/c=0
  - tag pipeline valid bits=0
  - rr pointer=0
  - done_cnt=0
- While in reset: rsp_valid=0, busy=0, req_ready=0.
- A reset asserted mid-operation drops every in-flight sort; no rsp_valid is produced for those sorts after release.
- Arbitration: a single combinational round-robin stage.
  - Search starts at the pointer and wraps modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1.
  - No valid requests gives req_ready=0.
- Transfer: occurs when req_valid[i] & req_ready[i] at a rising edge.
- Requester protocol: a requester holds req_valid and req_data stable until it sees its transfer. req_ready never depends on a requester's own data.
- Pointer: after a transfer from winner w, the pointer becomes (w+1) mod NREQ. With no transfer the pointer holds.
- Issue: on the transfer edge, the requester's {a,b,c} slice is registered into srt_a/b/c. The tag stage-0 entry receives valid=1 and id=w.
- No transfer: srt_a/b/c hold their previous values and stage-0 valid=0. Bubbles propagate as invalid tags.
- Tag pipeline: stages 0..LAT. Each edge, stage k+1 takes stage k.
  - Stage LAT aligns with srt_no1..3 being valid for the operands issued LAT edges earlier.
- Response: when stage-LAT valid=1, rsp_valid[id]=1 and rsp_id=id; otherwise rsp_valid=0.
  - rsp_data always mirrors the sorter outputs.
  - Requesters must accept a result in the cycle it appears; there is no backpressure.
- Latency: a transfer on edge E gives a response in the cycle after edge E+LAT.
  - Example, LAT=1: accept at edge E, response during cycle E+1..E+2.
- Throughput: 1 sort per cycle sustained; fully pipelined, no stalls.
- busy = OR of all tag-stage valid bits.
- done_cnt increments by 1 on every edge at which stage-LAT valid=1.
- Simultaneous events: issue and response may occur in the same cycle, for the same or different requesters. Each requester may have up to LAT+1 sorts in flight, returned in issue order.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random req_valid.
  - Required: req_ready=0, rsp_valid=0, busy=0, srt_a/b/c=0, done_cnt=0.
- Single request: NREQ=4, LAT=1, requester 2 sends {a,b,c}={3,7,5}, valid for one transfer.
  - Required: req_ready=4'b0100 at that edge; srt=3,7,5 after it.
  - One cycle later: rsp_valid=4'b0100, rsp_id=2, rsp_data={7,5,3}; then done_cnt=1, busy=0.
- Round-robin fairness: all 4 requesters valid continuously for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Responses in the same order, one per cycle; done_cnt=8.
- Pointer wrap and skip: pointer=3, only requesters 1 and 3 valid.
  - Required: grant 3, then 1, then 3; pointer is 2 after the grant to 1.
- Bubbles: requester 0 valid on alternate cycles with triples {0,0,0} and {7,0,7}.
  - Required: rsp_valid pulses alternate with zero cycles; rsp_data={0,0,0} then {7,7,0}.
- Exhaustive plus mid-op reset: all 512 triples spread across 4 requesters, checked against the 512-entry golden sorted-triple table.
  - Required: zero mismatches.
  - Then, with 2 sorts in flight, pulse rst=0: no rsp_valid follows and the pointer returns to 0.

Source files
------------

// File: rtl/sort_sched.sv
// Round-robin front end for one shared pipelined 3-input sorter.
// A combinational rotating-priority arbiter picks one requester per cycle.
// Its operand triple is registered into the sorter inputs. An id/valid tag
// travels alongside the sorter pipeline, so each sorted result is strobed
// back to the requester that issued it.
module sort_sched #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4,
    parameter int LAT   = 1,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*3*WIDTH-1:0] req_data,
    output logic [WIDTH-1:0]        srt_a,
    output logic [WIDTH-1:0]        srt_b,
    output logic [WIDTH-1:0]        srt_c,
    input  logic [WIDTH-1:0]        srt_no1,
    input  logic [WIDTH-1:0]        srt_no2,
    input  logic [WIDTH-1:0]        srt_no3,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [3*WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy,
    output logic [15:0]             done_cnt
);

    logic [IDW-1:0]             r_ptr;
    logic [WIDTH-1:0]           r_srt_a;
    logic [WIDTH-1:0]           r_srt_b;
    logic [WIDTH-1:0]           r_srt_c;
    logic [LAT:0]               r_tag_v;
    logic [LAT:0][IDW-1:0]      r_tag_id;
    logic [15:0]                r_done_cnt;

    logic [NREQ-1:0]            w_grant;
    logic [IDW-1:0]             w_win;
    logic [IDW-1:0]             w_idx;
    logic                       w_xfer;
    logic [3*WIDTH-1:0]         w_slice;
    logic [IDW-1:0]             w_ptr_nxt;

    // Index of the requester 'off' positions after the pointer, wrapping at NREQ.
    function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] ptr, input int off);
        int sum;
        sum = int'(ptr) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDW'(sum);
    endfunction

    // Round-robin search from the pointer; grants are suppressed while in reset.
    always_comb begin
        w_xfer  = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        w_grant = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_idx = f_wrap(r_ptr, off);
            if (!w_xfer && req_valid[w_idx]) begin
                w_xfer = 1'b1;
                w_win  = w_idx;
            end
        end
        if (!rst) begin
            w_xfer = 1'b0;
        end
        if (w_xfer) begin
            w_grant = NREQ'(1) << w_win;
        end
    end

    assign w_slice   = req_data[w_win*3*WIDTH +: 3*WIDTH];
    assign w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + 1'b1;

    // Register the winner's operands and advance the pointer past it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_srt_a <= '0;
            r_srt_b <= '0;
            r_srt_c <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_srt_a <= w_slice[3*WIDTH-1 -: WIDTH];
            r_srt_b <= w_slice[2*WIDTH-1 -: WIDTH];
            r_srt_c <= w_slice[WIDTH-1:0];
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Tag pipeline shadowing the sorter; idle cycles travel as invalid tags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= w_xfer;
            r_tag_id[0] <= w_win;
            for (int k = 1; k <= LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Count every result delivered at the end of the tag pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_cnt <= '0;
        end else if (r_tag_v[LAT]) begin
            r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign req_ready = w_grant;
    assign srt_a     = r_srt_a;
    assign srt_b     = r_srt_b;
    assign srt_c     = r_srt_c;
    assign rsp_valid = r_tag_v[LAT] ? (NREQ'(1) << r_tag_id[LAT]) : '0;
    assign rsp_id    = r_tag_id[LAT];
    assign rsp_data  = {srt_no1, srt_no2, srt_no3};
    assign busy      = |r_tag_v;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_sort_sched.sv
// Directed bench for sort_sched with a behavioural single-stage sorter.
module tb_sort_sched;
    localparam int W = 3;
    localparam int N = 4;
    localparam int L = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*3*W-1:0] req_data;
    logic [W-1:0]     srt_a, srt_b, srt_c;
    logic [W-1:0]     srt_no1, srt_no2, srt_no3;
    logic [N-1:0]     rsp_valid;
    logic [3*W-1:0]   rsp_data;
    logic [1:0]       rsp_id;
    logic             busy;
    logic [15:0]      done_cnt;

    int n_err = 0;
    int n_chk = 0;
    int exp_done = 0;

    typedef struct {
        int         id;
        logic [8:0] din;
        logic [8:0] dout;
    } vec_t;

    vec_t       tbl [8];
    logic [8:0] fair_in [4];
    logic [8:0] fair_out [4];
    logic [8:0] gold [512];
    logic [8:0] tv;
    logic [8:0] s_pipe [L];

    sort_sched #(.WIDTH(W), .NREQ(N), .LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .srt_a(srt_a), .srt_b(srt_b), .srt_c(srt_c),
        .srt_no1(srt_no1), .srt_no2(srt_no2), .srt_no3(srt_no3),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] sort3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        logic [2:0] x, y, z, t;
        x = a; y = b; z = c;
        if (x < y) begin t = x; x = y; y = t; end
        if (y < z) begin t = y; y = z; z = t; end
        if (x < y) begin t = x; x = y; y = t; end
        return {x, y, z};
    endfunction

    // Sorter model: L registered stages, no1 largest.
    always @(posedge clk) begin
        s_pipe[0] <= sort3(srt_a, srt_b, srt_c);
        for (int k = 1; k < L; k++) s_pipe[k] <= s_pipe[k-1];
    end
    assign {srt_no1, srt_no2, srt_no3} = s_pipe[L-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int id, input logic [8:0] d);
        req_data[id*9 +: 9] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2, 9'o375, 9'o753};
        tbl[1] = '{0, 9'o000, 9'o000};
        tbl[2] = '{1, 9'o777, 9'o777};
        tbl[3] = '{3, 9'o123, 9'o321};
        tbl[4] = '{0, 9'o661, 9'o661};
        tbl[5] = '{2, 9'o414, 9'o441};
        tbl[6] = '{1, 9'o070, 9'o700};
        tbl[7] = '{3, 9'o536, 9'o653};
        fair_in[0] = 9'o123; fair_out[0] = 9'o321;
        fair_in[1] = 9'o406; fair_out[1] = 9'o640;
        fair_in[2] = 9'o551; fair_out[2] = 9'o551;
        fair_in[3] = 9'o272; fair_out[3] = 9'o722;
        for (int v = 0; v < 512; v++) begin
            tv = 9'(v);
            gold[v] = sort3(tv[8:6], tv[5:3], tv[2:0]);
        end

        // Reset held with random request activity.
        rst = 1'b0;
        req_valid = 4'($urandom);
        req_data = {4'($urandom), 32'($urandom)};
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_srt", {srt_a, srt_b, srt_c}, 0);
            chk("rst_done", done_cnt, 0);
            tick();
            req_valid = 4'($urandom);
        end
        req_valid = '0;
        rst = 1'b1;

        // Round-robin fairness with all requesters asserting.
        for (int i = 0; i < 4; i++) put(i, fair_in[i]);
        for (int n = 0; n <= 10; n++) begin
            req_valid = (n < 8) ? 4'hF : 4'h0;
            #1;
            if (n < 8) chk("rr_grant", req_ready, 4'b1 << (n % 4));
            if (n >= 2 && n <= 9) begin
                chk("rr_rsp_valid", rsp_valid, 4'b1 << ((n - 2) % 4));
                chk("rr_rsp_id", rsp_id, (n - 2) % 4);
                chk("rr_rsp_data", rsp_data, fair_out[(n - 2) % 4]);
            end else begin
                chk("rr_rsp_idle", rsp_valid, 0);
            end
            tick();
        end
        exp_done = 8;
        chk("rr_done", done_cnt, exp_done);
        chk("rr_busy", busy, 0);

        // Single isolated requests from the vector table.
        for (int i = 0; i < 8; i++) begin
            put(tbl[i].id, tbl[i].din);
            req_valid = 4'b1 << tbl[i].id;
            #1;
            chk("one_ready", req_ready, 4'b1 << tbl[i].id);
            tick();
            req_valid = '0;
            chk("one_srt", {srt_a, srt_b, srt_c}, tbl[i].din);
            chk("one_rsp_early", rsp_valid, 0);
            tick();
            chk("one_rsp_valid", rsp_valid, 4'b1 << tbl[i].id);
            chk("one_rsp_id", rsp_id, tbl[i].id);
            chk("one_rsp_data", rsp_data, tbl[i].dout);
            tick();
            exp_done++;
            chk("one_done", done_cnt, exp_done);
            chk("one_busy", busy, 0);
        end

        // Pointer wrap and skip: park pointer at 3, then only 1 and 3 request.
        put(2, 9'o000);
        req_valid = 4'b0100;
        #1;
        chk("wrap_setup", req_ready, 4'b0100);
        tick();
        put(1, 9'o264);
        put(3, 9'o713);
        req_valid = 4'b1010;
        #1;
        chk("wrap_grant3", req_ready, 4'b1000);
        tick();
        put(3, 9'o052);
        #1;
        chk("wrap_grant1", req_ready, 4'b0010);
        chk("wrap_rsp2", rsp_valid, 4'b0100);
        tick();
        req_valid = 4'b1110;
        #1;
        chk("wrap_ptr2", req_ready, 4'b0100);
        req_valid = 4'b1010;
        #1;
        chk("wrap_grant3b", req_ready, 4'b1000);
        chk("wrap_rsp3_id", rsp_id, 3);
        chk("wrap_rsp3_data", rsp_data, 9'o731);
        tick();
        req_valid = '0;
        chk("wrap_rsp1_valid", rsp_valid, 4'b0010);
        chk("wrap_rsp1_data", rsp_data, 9'o642);
        tick();
        chk("wrap_rsp3b_valid", rsp_valid, 4'b1000);
        chk("wrap_rsp3b_data", rsp_data, 9'o520);
        tick();
        chk("wrap_idle", rsp_valid, 0);
        exp_done += 4;
        chk("wrap_done", done_cnt, exp_done);

        // Bubbles: requester 0 on alternate cycles.
        put(0, 9'o000);
        req_valid = 4'b0001;
        #1;
        chk("bub_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("bub_idle0", rsp_valid, 0);
        tick();
        put(0, 9'o707);
        req_valid = 4'b0001;
        #1;
        chk("bub_rsp0_valid", rsp_valid, 4'b0001);
        chk("bub_rsp0_data", rsp_data, 9'o000);
        tick();
        req_valid = '0;
        #1;
        chk("bub_idle1", rsp_valid, 0);
        tick();
        chk("bub_rsp1_valid", rsp_valid, 4'b0001);
        chk("bub_rsp1_data", rsp_data, 9'o770);
        tick();
        chk("bub_idle2", rsp_valid, 0);
        exp_done += 2;

        // Every triple, one per cycle, round-robin across requesters.
        for (int n = 0; n <= 513; n++) begin
            if (n < 512) begin
                put(n % 4, 9'(n));
                req_valid = 4'b1 << (n % 4);
            end else begin
                req_valid = '0;
            end
            #1;
            if (n < 512) chk("exh_ready", req_ready, 4'b1 << (n % 4));
            if (n >= 2) begin
                chk("exh_valid", rsp_valid, 4'b1 << ((n - 2) % 4));
                chk("exh_data", rsp_data, gold[n - 2]);
            end
            tick();
        end
        exp_done += 512;
        chk("exh_done", done_cnt, exp_done);
        chk("exh_busy", busy, 0);

        // Reset with two sorts in flight.
        put(1, 9'o123);
        req_valid = 4'b0010;
        tick();
        put(2, 9'o456);
        req_valid = 4'b0100;
        #1;
        chk("mid_busy", busy, 1);
        tick();
        req_valid = '0;
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy_rst", busy, 0);
        chk("mid_done_rst", done_cnt, 0);
        chk("mid_srt_rst", {srt_a, srt_b, srt_c}, 0);
        tick();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("mid_no_rsp", rsp_valid, 0);
            chk("mid_no_busy", busy, 0);
            tick();
        end
        req_valid = 4'hF;
        #1;
        chk("mid_ptr0", req_ready, 4'b0001);
        req_valid = '0;
        chk("mid_done", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
